// File: rtl/pinky_fcvt.sv
// Multi-cycle signed-integer <-> float converter with valid/ready handshakes on both sides.
// Define FCVT_RNE_EN to make ITOF round to nearest-even instead of truncating.
module pinky_fcvt #(
   parameter int WIDTH = 16,
   parameter int EXP_W = 8,
   parameter int BIAS  = 127
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic [WIDTH-1:0] operand,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             inexact,
   output logic             overflow
);
   localparam int MANT_W  = WIDTH - 1 - EXP_W;
   localparam int EW2     = EXP_W + 2;
   localparam int UW      = EXP_W + 1;
   localparam int EXP_MAX = (1 << EXP_W) - 1;
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, UNPACK, NORM, PACK, HOLD} state_t;

   state_t                 state;
   logic                   mode_r;
   logic [WIDTH-1:0]       op_r;
   logic                   sign_r;
   logic [WIDTH-1:0]       mag_r;
   logic                   zero_r;
   logic [EW2-1:0]         exp_r;
   logic signed [UW-1:0]   u_r;

   int                     lz;
   int                     e_int;
   int                     ui;
   logic [MANT_W-1:0]      i_mant;
   logic [MANT_W-1:0]      mant_f;
   logic [WIDTH-1:0]       mag_v;
   logic [WIDTH-1:0]       p_result;
   logic                   p_inexact;
   logic                   p_overflow;
`ifdef FCVT_RNE_EN
   logic                   guard;
   logic                   sticky;
`endif

   function automatic int lzc(input logic [WIDTH-1:0] v);
      int n;
      n = WIDTH;
      for (int i = 0; i < WIDTH; i++)
         if (v[i]) n = WIDTH - 1 - i;
      return n;
   endfunction

   assign lz = lzc(mag_r);

   always_comb begin
      p_result   = '0;
      p_inexact  = 1'b0;
      p_overflow = 1'b0;
      i_mant     = mag_r[WIDTH-2 -: MANT_W];
      mant_f     = mag_r[MANT_W-1:0];
      mag_v      = '0;
      e_int      = int'(exp_r);
      ui         = int'(u_r);
`ifdef FCVT_RNE_EN
      guard      = mag_r[WIDTH-2-MANT_W];
      sticky     = (mag_r << (MANT_W + 2)) != '0;
`endif
      if (!mode_r) begin
         if (!zero_r) begin
            // mag_r is normalised: leading one at the MSB, fraction follows
            p_inexact = (mag_r << (MANT_W + 1)) != '0;
`ifdef FCVT_RNE_EN
            if (guard && (sticky || i_mant[0])) begin
               if (&i_mant) begin
                  i_mant = '0;
                  e_int  = e_int + 1;
               end else begin
                  i_mant = i_mant + MANT_W'(1);
               end
            end
`endif
            if (e_int >= EXP_MAX) begin
               p_overflow = 1'b1;
               p_result   = {sign_r, EXP_W'(EXP_MAX - 1), {MANT_W{1'b1}}};
            end else begin
               p_result   = {sign_r, e_int[EXP_W-1:0], i_mant};
            end
         end
      end else begin
         if (exp_r[EXP_W-1:0] == '0) begin
            p_inexact = mant_f != '0;
         end else if (&exp_r[EXP_W-1:0]) begin
            p_overflow = 1'b1;
            p_result   = (!sign_r || mant_f != '0) ? MAX_POS : MIN_NEG;
         end else if (ui < 0) begin
            p_inexact = 1'b1;
         end else if (ui >= WIDTH - 1) begin
            if (sign_r && ui == WIDTH - 1 && mant_f == '0) begin
               p_result = MIN_NEG;
            end else begin
               p_overflow = 1'b1;
               p_result   = sign_r ? MIN_NEG : MAX_POS;
            end
         end else begin
            if (ui >= MANT_W) begin
               mag_v = mag_r << (ui - MANT_W);
            end else begin
               mag_v     = mag_r >> (MANT_W - ui);
               p_inexact = (mag_r << (WIDTH - MANT_W + ui)) != '0;
            end
            p_result = sign_r ? -mag_v : mag_v;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         inexact   <= 1'b0;
         overflow  <= 1'b0;
         mode_r    <= 1'b0;
         op_r      <= '0;
         sign_r    <= 1'b0;
         mag_r     <= '0;
         zero_r    <= 1'b0;
         exp_r     <= '0;
         u_r       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_r     <= operand;
                  mode_r   <= mode;
                  in_ready <= 1'b0;
                  state    <= UNPACK;
               end
            end
            UNPACK: begin
               sign_r <= op_r[WIDTH-1];
               if (!mode_r) begin
                  mag_r <= op_r[WIDTH-1] ? -op_r : op_r;
               end else begin
                  mag_r <= {{EXP_W{1'b0}}, 1'b1, op_r[MANT_W-1:0]};
                  exp_r <= {2'b00, op_r[WIDTH-2 -: EXP_W]};
               end
               state <= NORM;
            end
            NORM: begin
               if (!mode_r) begin
                  zero_r <= mag_r == '0;
                  mag_r  <= mag_r << lz;
                  exp_r  <= EW2'(BIAS + WIDTH - 1 - lz);
               end else begin
                  u_r <= UW'($signed({1'b0, exp_r[EXP_W-1:0]}) - BIAS);
               end
               state <= PACK;
            end
            PACK: begin
               result    <= p_result;
               inexact   <= p_inexact;
               overflow  <= p_overflow;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pinky_fcvt.sv
// Self-checking bench for pinky_fcvt: directed cases, random ITOF/FTOI against an arithmetic model,
// backpressure and mid-operation reset.
module tb_pinky_fcvt;
   localparam int W = 16;
   localparam int E = 8;
   localparam int M = 7;
   localparam int B = 127;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic         mode;
   logic [W-1:0] operand;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         inexact;
   logic         overflow;

   int errors = 0;
   int checks = 0;
   logic [17:0] want;

   always #5 clk = ~clk;

   pinky_fcvt #(.WIDTH(W), .EXP_W(E), .BIAS(B)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .operand(operand), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .inexact(inexact), .overflow(overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Value-level integer to float: find the power of two, scale, truncate or round.
   function automatic logic [17:0] model_itof(input logic [W-1:0] op);
      longint v, m, q, rem, den;
`ifdef FCVT_RNE_EN
      longint half;
`endif
      int p;
      logic [W-1:0] r;
      logic ix, ov;
      v = longint'($signed(op));
      r = '0; ix = 1'b0; ov = 1'b0;
      if (v != 0) begin
         m = (v < 0) ? -v : v;
         p = 0;
         while ((longint'(1) << (p + 1)) <= m) p++;
         den = longint'(1) << p;
         q   = (m * (longint'(1) << M)) / den;
         rem = (m * (longint'(1) << M)) % den;
         ix  = rem != 0;
`ifdef FCVT_RNE_EN
         half = den / 2;
         if (p > 0 && (rem > half || (rem == half && q[0]))) q++;
         if (q == (longint'(1) << (M + 1))) begin
            q = q / 2;
            p++;
         end
`endif
         if (B + p >= (1 << E) - 1) begin
            ov = 1'b1;
            r  = {v < 0, 8'hFE, 7'h7F};
         end else begin
            r  = {v < 0, 8'(B + p), 7'(q - (longint'(1) << M))};
         end
      end
      return {ov, ix, r};
   endfunction

   // Value-level float to integer: evaluate sig * 2^(e-B-M), truncate toward zero, range-check.
   function automatic logic [17:0] model_ftoi(input logic [W-1:0] f);
      logic s;
      int e, u, mt;
      longint sig, mag, den, lim;
      logic [W-1:0] r;
      logic ix, ov;
      s = f[15]; e = int'(f[14:7]); mt = int'(f[6:0]);
      r = '0; ix = 1'b0; ov = 1'b0;
      if (e == 0) begin
         ix = mt != 0;
      end else if (e == 255) begin
         ov = 1'b1;
         r  = (!s || mt != 0) ? 16'h7FFF : 16'h8000;
      end else begin
         sig = 128 + mt;
         u   = e - B;
         if (u >= M) begin
            mag = (u > 40) ? (longint'(1) << 50) : sig * (longint'(1) << (u - M));
         end else if (M - u >= 60) begin
            mag = 0; ix = 1'b1;
         end else begin
            den = longint'(1) << (M - u);
            mag = sig / den;
            ix  = (sig % den) != 0;
         end
         lim = s ? 32768 : 32767;
         if (mag > lim) begin
            ov = 1'b1;
            r  = s ? 16'h8000 : 16'h7FFF;
         end else begin
            r  = s ? 16'(-mag) : 16'(mag);
         end
      end
      return {ov, ix, r};
   endfunction

   task automatic check_out(input string tag);
      check({tag, " result"}, 32'(result), 32'(want[15:0]));
      check({tag, " inexact"}, 32'(inexact), 32'(want[16]));
      check({tag, " overflow"}, 32'(overflow), 32'(want[17]));
   endtask

   task automatic start(input logic m, input logic [W-1:0] op, input string tag);
      int n;
      want = m ? model_ftoi(op) : model_itof(op);
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " idle_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; mode = m; operand = op;
      @(negedge clk);
      in_valid = 1'b0; mode = 1'($urandom); operand = 16'($urandom);
      check({tag, " busy_ready"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check({tag, " early_valid"}, 32'(out_valid), 32'd0);
         @(negedge clk);
      end
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check_out(tag);
   endtask

   task automatic finish_op(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " valid_clear"}, 32'(out_valid), 32'd0);
      check({tag, " ready_back"}, 32'(in_ready), 32'd1);
   endtask

   task automatic directed(input logic m, input logic [W-1:0] op, input logic [W-1:0] r,
                           input logic ix, input logic ov, input string tag);
      start(m, op, tag);
      check({tag, " const_result"}, 32'(result), 32'(r));
      check({tag, " const_inexact"}, 32'(inexact), 32'(ix));
      check({tag, " const_overflow"}, 32'(overflow), 32'(ov));
      finish_op(tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; operand = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result", 32'(result), 32'd0);
      check("reset inexact", 32'(inexact), 32'd0);
      check("reset overflow", 32'(overflow), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      directed(1'b0, 16'h0001, 16'h3F80, 1'b0, 1'b0, "itof_one");
      directed(1'b0, 16'hFFFB, 16'hC0A0, 1'b0, 1'b0, "itof_m5");
      directed(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, "itof_zero");
`ifdef FCVT_RNE_EN
      directed(1'b0, 16'h7FFF, 16'h4700, 1'b1, 1'b0, "itof_max");
`else
      directed(1'b0, 16'h7FFF, 16'h46FF, 1'b1, 1'b0, "itof_max");
`endif
      directed(1'b0, 16'h8000, 16'hC700, 1'b0, 1'b0, "itof_minneg");
      directed(1'b1, 16'h4120, 16'h000A, 1'b0, 1'b0, "ftoi_10");
      directed(1'b1, 16'hC0A0, 16'hFFFB, 1'b0, 1'b0, "ftoi_m5");
      directed(1'b1, 16'h3F00, 16'h0000, 1'b1, 1'b0, "ftoi_half");
      directed(1'b1, 16'h4780, 16'h7FFF, 1'b0, 1'b1, "ftoi_sat");
      directed(1'b1, 16'hC700, 16'h8000, 1'b0, 1'b0, "ftoi_minneg");
      directed(1'b1, 16'h7F80, 16'h7FFF, 1'b0, 1'b1, "ftoi_inf");
      directed(1'b1, 16'hFF80, 16'h8000, 1'b0, 1'b1, "ftoi_ninf");
      directed(1'b1, 16'h0001, 16'h0000, 1'b1, 1'b0, "ftoi_denorm");

      for (int k = 0; k < 40; k++) begin
         start(1'b0, 16'($urandom), "rnd_itof");
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("rnd_itof hold_valid", 32'(out_valid), 32'd1);
            check_out("rnd_itof hold");
         end
         finish_op("rnd_itof");
      end
      for (int k = 0; k < 40; k++) begin
         if (k % 5 == 0)
            start(1'b1, 16'($urandom), "rnd_ftoi");
         else
            start(1'b1, {1'($urandom), 8'($urandom_range(110, 150)), 7'($urandom)}, "rnd_ftoi");
         finish_op("rnd_ftoi");
      end

      // Backpressure: result held, then a request raised during HOLD waits for IDLE.
      start(1'b0, 16'h0003, "bp");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp hold_valid", 32'(out_valid), 32'd1);
         check("bp hold_ready", 32'(in_ready), 32'd0);
         check("bp hold_result", 32'(result), 32'h4040);
      end
      in_valid = 1'b1; mode = 1'b1; operand = 16'h4120;
      @(negedge clk);
      check("bp not_taken_ready", 32'(in_ready), 32'd0);
      check("bp not_taken_valid", 32'(out_valid), 32'd1);
      check("bp not_taken_result", 32'(result), 32'h4040);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp handshake_valid", 32'(out_valid), 32'd0);
      check("bp handshake_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp accepted_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("bp second_early", 32'(out_valid), 32'd0);
         @(negedge clk);
      end
      check("bp second_valid", 32'(out_valid), 32'd1);
      check("bp second_result", 32'(result), 32'h000A);
      finish_op("bp");

      // Reset while the request sits in NORM.
      in_valid = 1'b1; mode = 1'b0; operand = 16'h0005;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst result", 32'(result), 32'd0);
      check("rst inexact", 32'(inexact), 32'd0);
      check("rst overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst no_output", 32'(out_valid), 32'd0);
      end
      directed(1'b0, 16'h0003, 16'h4040, 1'b0, 1'b0, "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pinky_fcvt.md
Name: pinky_fcvt

Overview:
Parametrised, multi-cycle converter between integer and float. Handles signed integer to float (ITOF) and float to signed integer (FTOI). It generalises the fixed 16-bit ITOF-only FPU path to configurable word, exponent and mantissa widths, adds an FTOI mode, and uses valid/ready backpressure on both sides. It sits beside the stage-3 ALU and is driven by the itof/ftoi opcodes.

Parameters:
WIDTH, 16, integer and float word width in bits
EXP_W, 8, exponent field width; mantissa width MANT_W = WIDTH-1-EXP_W (localparam, must be >= 2)
BIAS, 127, exponent bias

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
in_valid  input  1  request present
in_ready  output  1  unit can accept a request
mode  input  1  0 = ITOF, 1 = FTOI; sampled at accept
operand  input  WIDTH  integer (ITOF) or float {sign, exp, mant} (FTOI); sampled at accept
out_valid  output  1  result present
out_ready  input  1  consumer takes result
result  output  WIDTH  converted value
inexact  output  1  nonzero bits were discarded
overflow  output  1  result saturated

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, inexact=0, overflow=0, FSM=IDLE. Reset mid-operation abandons the request; no output is produced for it.
- FSM states: IDLE -> UNPACK -> NORM -> PACK -> HOLD -> IDLE. One request in flight at a time.
- IDLE: in_ready=1. When in_valid=1 at the clock edge, operand and mode are latched and the FSM goes to UNPACK. in_ready=0 in every other state.
- UNPACK: register sign and magnitude.
  - ITOF: magnitude = |operand| as WIDTH-bit unsigned; most-negative input gives 2^(WIDTH-1).
  - FTOI: split into sign, exp and {1, mant}.
- NORM:
  - ITOF: leading-zero count d of magnitude; exp = BIAS+WIDTH-1-d.
  - FTOI: u = exp-BIAS (signed, EXP_W+1 bits); compute the shift amount.
- PACK: compute result and flags; go to HOLD.
- Latency: out_valid rises 3 edges after the accepting edge (accept at edge T, out_valid=1 after edge T+3). Latency is fixed, including zero operands.
- HOLD: out_valid=1. result, inexact and overflow stay stable until an edge with out_ready=1. At that edge out_valid clears and the FSM returns to IDLE. A new request can be accepted on the following edge; there is no same-edge accept.
- ITOF rules:
  - Zero input gives result 0 and no flags.
  - Otherwise result = {sign, exp, next MANT_W bits below the leading one}, truncated.
  - inexact=1 if any lower bits are dropped.
  - If exp >= 2^EXP_W-1, result = {sign, all-ones-minus-1 exp, all-ones mant} and overflow=1.
- FTOI rules:
  - exp==0 (zero or denormal) gives 0; inexact=1 if mant!=0.
  - exp all-ones gives overflow=1 and result 2^(WIDTH-1)-1 if the sign bit is clear or mant!=0, else -2^(WIDTH-1).
  - u<0 gives 0 with inexact=1.
  - u >= WIDTH-1 saturates: 2^(WIDTH-1)-1 if positive, -2^(WIDTH-1) if negative, with overflow=1. Exception: exactly -2^(WIDTH-1) is exact.
  - Otherwise {1, mant} is shifted left by u-MANT_W or right by MANT_W-u. Truncation is toward zero, inexact is set on dropped bits, and the value is negated if the sign bit is set.
- Simultaneous in_valid and out_ready while in HOLD: out_ready is honoured; in_valid waits for IDLE.

Optional Feature:
FCVT_RNE_EN:
- Defined: ITOF rounds to nearest, ties to even, using guard/sticky bits. A mantissa carry increments exp, and exp overflow saturates as above. inexact still reports dropped nonzero bits. Latency is unchanged; rounding happens in PACK.
- Undefined: truncation only.
- FTOI is always toward zero.

Test Plan:
1. ITOF 0x0001 -> result 0x3F80, inexact=0, overflow=0, out_valid 3 edges after accept.
2. ITOF 0xFFFB (-5) -> 0xC0A0. ITOF 0x0000 -> 0x0000 with no flags.
3. ITOF 0x7FFF -> 0x46FF with inexact=1. With FCVT_RNE_EN -> 0x4700 with inexact=1.
4. FTOI conversions:
   - 0x4120 -> 0x000A.
   - 0xC0A0 -> 0xFFFB.
   - 0x3F00 -> 0x0000 with inexact=1.
   - 0x4780 -> 0x7FFF with overflow=1.
   - 0xC700 -> 0x8000 with overflow=0.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid. result stays stable and in_ready stays 0. A new in_valid asserted during HOLD is accepted only on the edge after the out_ready handshake.
6. Assert reset for one cycle during NORM. Outputs immediately return to reset values, no result is emitted, and the next request completes normally.
